// File: rtl/key_arb_pkg.sv
// Shared types and constants for the key source arbiter: state encoding,
// source codes, field widths and the zero-duration rule.
package key_arb_pkg;

    localparam int KEY_W = 4;
    localparam int DUR_W = 7;

    localparam logic SRC_LIVE = 1'b0;
    localparam logic SRC_SONG = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIVE = 2'd1,
        SONG = 2'd2,
        GAP  = 2'd3
    } state_e;

    // A zero-length autoplay note still sounds for one duration unit.
    function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/key_arb_timer.sv
// Loadable, non-wrapping down-counter. done is high once the count is at or
// below one, so the cycle that samples done is the last cycle of the interval.
module key_arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        // NOTE: default first, so no path through this block can infer a latch.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/key_source_arbiter.sv
// Arbitrates the tone generator between live keyboard and autoplay song.
// Optional follow-along hit counter is built only when KEY_ARB_HIT_EN is defined.
module key_source_arbiter
    import key_arb_pkg::*;
#(
    parameter int TICK_CYC = 2500000,
    parameter int GAP_CYC  = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             live_on,
    input  logic [KEY_W-1:0] live_key,
    input  logic             song_on,
    input  logic [KEY_W-1:0] song_key,
    input  logic [DUR_W-1:0] song_dur,
    input  logic             mode_auto,
    input  logic             pause,
    output logic             key_on,
    output logic [KEY_W-1:0] key,
    output logic             src,
    output logic             song_hold,
    output logic [7:0]       hit_cnt
);

    localparam int DUR_CNT_W = $clog2(127 * TICK_CYC + 1);
    localparam int GAP_CNT_W = $clog2(GAP_CYC + 1);

    state_e           state_q, state_d;
    logic             key_on_q, key_on_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             src_q, src_d;
    logic             song_hold_q, song_hold_d;
    logic             song_armed_q, song_armed_d;

    logic song_rise;
    logic live_entry;
    logic song_entry;
    logic gap_load;
    logic gap_done;
    logic dur_done;

    logic [DUR_CNT_W-1:0] dur_load_val;
    logic [GAP_CNT_W-1:0] gap_load_val;

    assign dur_load_val = DUR_CNT_W'(dur_eff(song_dur)) * DUR_CNT_W'(TICK_CYC);
    assign gap_load_val = GAP_CNT_W'(GAP_CYC);

    // song_armed means "song_on was low last cycle"; clearing it in reset keeps
    // a song_on held high through reset from counting as a rising edge.
    assign song_armed_d = ~song_on;
    assign song_rise    = song_on & song_armed_q;

    key_arb_timer #(.W(DUR_CNT_W)) u_dur_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (song_entry),
        .load_val (dur_load_val),
        .done     (dur_done)
    );

    key_arb_timer #(.W(GAP_CNT_W)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .done     (gap_done)
    );

    always_comb begin
        state_d    = state_q;
        key_on_d   = key_on_q;
        key_d      = key_q;
        src_d      = src_q;
        live_entry = 1'b0;
        song_entry = 1'b0;
        gap_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (live_on) begin
                    live_entry = 1'b1;
                end else if (song_rise && mode_auto && !pause) begin
                    song_entry = 1'b1;
                end
            end
            LIVE: begin
                if (!live_on) begin
                    state_d  = GAP;
                    key_on_d = 1'b0;
                    gap_load = 1'b1;
                end else begin
                    key_d = live_key;
                end
            end
            GAP: begin
                if (live_on) begin
                    live_entry = 1'b1;
                end else if (gap_done) begin
                    state_d = IDLE;
                end
            end
            SONG: begin
                if (live_on) begin
                    live_entry = 1'b1;
                end else if (dur_done || !song_on || pause || !mode_auto) begin
                    state_d  = IDLE;
                    key_on_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (live_entry) begin
            state_d  = LIVE;
            key_on_d = 1'b1;
            key_d    = live_key;
            src_d    = SRC_LIVE;
        end
        if (song_entry) begin
            state_d  = SONG;
            key_on_d = 1'b1;
            key_d    = song_key;
            src_d    = SRC_SONG;
        end

        song_hold_d = (state_d == LIVE) || (state_d == GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            key_on_q     <= 1'b0;
            key_q        <= '0;
            src_q        <= SRC_LIVE;
            song_hold_q  <= 1'b0;
            song_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_on_q     <= key_on_d;
            key_q        <= key_d;
            src_q        <= src_d;
            song_hold_q  <= song_hold_d;
            song_armed_q <= song_armed_d;
        end
    end

    assign key_on    = key_on_q;
    assign key       = key_q;
    assign src       = src_q;
    assign song_hold = song_hold_q;

`ifdef KEY_ARB_HIT_EN
    logic [KEY_W-1:0] last_song_key_q, last_song_key_d;
    logic [7:0]       hit_cnt_q, hit_cnt_d;

    always_comb begin
        last_song_key_d = song_entry ? song_key : last_song_key_q;
        hit_cnt_d       = hit_cnt_q;
        if (live_entry && (live_key == last_song_key_q) && (hit_cnt_q != 8'hFF)) begin
            hit_cnt_d = hit_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_song_key_q <= '0;
            hit_cnt_q       <= '0;
        end else begin
            last_song_key_q <= last_song_key_d;
            hit_cnt_q       <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: doc/key_source_arbiter.md
KEY_SOURCE_ARBITER -- requirements
Module: key_source_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TICK_CYC  2500000  clk cycles per song duration unit
  GAP_CYC   5000000  silent cycles forced after a live note ends
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
  clk        in   1  system clock
  rst        in   1  synchronous, active-high reset
  live_on    in   1  keyboard key held
  live_key   in   4  keyboard key index
  song_on    in   1  autoplay note request
  song_key   in   4  autoplay key index
  song_dur   in   7  autoplay note length, in TICK_CYC units
  mode_auto  in   1  1 = autoplay permitted
  pause      in   1  1 = autoplay suspended
  key_on     out  1  tone enable to the tone generator
  key        out  4  key index to the tone generator
  src        out  1  0 = live, 1 = song
  song_hold  out  1  stall request to the song player
  hit_cnt    out  8  follow-along match count
REQ-003 There SHALL be exactly one clock, clk. Reset rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have four states: IDLE, LIVE, SONG, GAP.
REQ-005 All outputs SHALL be registered. An output SHALL change on the cycle after the input that causes it is sampled.
REQ-006 From IDLE, SONG or GAP, live_on=1 SHALL cause a transition to LIVE, with key_on=1, key=live_key, src=0.
REQ-007 In LIVE, key SHALL follow live_key every cycle. live_on=0 SHALL cause a transition to GAP with key_on=0.
REQ-008 GAP SHALL last GAP_CYC cycles and then go to IDLE. live_on=1 during GAP SHALL go to LIVE.
REQ-009 IDLE SHALL go to SONG on a song_on rising edge when mode_auto=1, pause=0 and live_on=0.
  - On entry: key=song_key, src=1, key_on=1.
  - song_dur is latched at entry.
REQ-010 SONG SHALL return to IDLE with key_on=0 on any of:
  - song_dur×TICK_CYC cycles elapsed;
  - song_on=0;
  - pause=1;
  - mode_auto=0.
REQ-011 song_dur=0 SHALL be treated as 1.
REQ-012 Simultaneous live_on and song_on rises in IDLE: live SHALL win.
REQ-013 A song_on rising edge that occurs in LIVE or GAP SHALL be discarded.
REQ-014 song_hold SHALL be 1 exactly while the state is LIVE or GAP.
REQ-015 When key_on=0, key and src SHALL hold their last values.
REQ-016 The duration counter SHALL be wide enough for 127×TICK_CYC. The gap counter SHALL be wide enough for GAP_CYC. Neither counter SHALL wrap.

Reset
REQ-017 rst=1 SHALL force the following on the next edge, overriding any mid-note or mid-gap state:
  - state IDLE, key_on=0, key=0, src=0, song_hold=0, hit_cnt=0;
  - all counters and the last-song-key register cleared.
REQ-018 The song_on edge detector SHALL reset to 0, so that song_on held high through reset does not start a note.

Configuration
REQ-019 Macro KEY_ARB_HIT_EN, when defined:
  - the block SHALL latch song_key on every SONG entry;
  - hit_cnt SHALL increment on each LIVE entry whose live_key equals the latched song key;
  - hit_cnt SHALL saturate at 255.
REQ-020 Without KEY_ARB_HIT_EN, hit_cnt SHALL be constant 0 and no comparison logic SHALL exist.

Structure
REQ-021 Package key_arb_pkg SHALL hold:
  - the state enum;
  - SRC_LIVE=0 and SRC_SONG=1;
  - KEY_W=4 and DUR_W=7.
REQ-022 Sub-module key_arb_timer SHALL provide a loadable down-counter with a done flag. It SHALL be used for both the gap timer and the duration/tick timers.

Verification (TICK_CYC=4, GAP_CYC=3)
REQ-023 Reset: rst=1 for 2 cycles with song_on=1 -> all outputs 0. No note starts after rst falls.
REQ-024 Song note: mode_auto=1, song_on rises with song_key=5, song_dur=3 -> key_on=1, key=5, src=1 for 12 cycles, then key_on=0.
REQ-025 Preemption: live_on=1 with live_key=2 mid-song -> next cycle key=2, src=0, song_hold=1. On release: key_on=0 with song_hold=1 for 3 cycles, then song_hold=0.
REQ-026 Tie and pause:
  - simultaneous live_on and song_on rises -> src=0;
  - pause=1 mid-note -> key_on=0 next cycle;
  - song_dur=0 -> 4-cycle note.
REQ-027 Hit count: song key 5 played, then live key 5 -> hit_cnt=1. 300 matching presses -> hit_cnt=255. Without the macro -> hit_cnt stays 0.
